// File: rtl/cpu_bus_pkg.sv
// Shared types, constants and helpers for the host-to-register-slave router.
package cpu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ACK = 2'd1,
    RESP     = 2'd2
  } state_e;

  localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

  function automatic int sel_bits(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear beats increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clr,
  input  logic             i_inc,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_inc && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cpu_bus_router.sv
// Routes single host register requests to one of NUM_SLAVES slaves,
// with ack timeout, error/drop accounting and a registered response.
module cpu_bus_router
  import cpu_bus_pkg::*;
#(
  parameter int NUM_SLAVES     = 4,
  parameter int ADDR_WIDTH     = 17,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             up_req,
  input  logic                             up_req_is_wr,
  input  logic [ADDR_WIDTH-1:0]            up_addr,
  input  logic [DATA_WIDTH-1:0]            up_wr_data,
  input  logic [DATA_WIDTH-1:0]            up_wr_biten,
  output logic                             up_rd_ack,
  output logic                             up_wr_ack,
  output logic [DATA_WIDTH-1:0]            up_rd_data,
  output logic [NUM_SLAVES-1:0]            dn_req,
  output logic                             dn_req_is_wr,
  output logic [ADDR_WIDTH-1:0]            dn_addr,
  output logic [DATA_WIDTH-1:0]            dn_wr_data,
  output logic [DATA_WIDTH-1:0]            dn_wr_biten,
  input  logic [NUM_SLAVES-1:0]            dn_rd_ack,
  input  logic [NUM_SLAVES-1:0]            dn_wr_ack,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] dn_rd_data,
  input  logic                             clear_counts,
  output logic [7:0]                       err_count,
  output logic [7:0]                       drop_count
);

  localparam int SB = sel_bits(NUM_SLAVES);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DATA_WIDTH-1:0] TO_DATA = DATA_WIDTH'(TIMEOUT_DATA);

  state_e                r_state, w_state;
  logic [SB-1:0]         r_sel, w_sel;
  logic                  w_mapped;
  logic                  r_is_wr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wr_data, r_wr_biten;
  logic [CW-1:0]         r_cnt, w_cnt;
  logic [NUM_SLAVES-1:0] r_dn_req, w_dn_req;
  logic                  r_rd_ack, w_rd_ack;
  logic                  r_wr_ack, w_wr_ack;
  logic [DATA_WIDTH-1:0] r_rd_data, w_rd_data;
  logic                  w_latch, w_err_inc, w_drop_inc;
  logic                  w_hit_rd, w_hit_wr;
  logic [DATA_WIDTH-1:0] w_slv_data;

  assign w_sel    = up_addr[ADDR_WIDTH-1 -: SB];
  assign w_mapped = (32'(w_sel) < 32'(NUM_SLAVES));

  always_comb begin
    w_hit_rd   = 1'b0;
    w_hit_wr   = 1'b0;
    w_slv_data = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (r_sel == SB'(i)) begin
        w_hit_rd   = dn_rd_ack[i];
        w_hit_wr   = dn_wr_ack[i];
        w_slv_data = dn_rd_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Counter is 0 on the dn_req cycle; acks are still honoured on the
  // cycle it holds TIMEOUT_CYCLES, after which the error response fires.
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_dn_req   = '0;
    w_rd_ack   = 1'b0;
    w_wr_ack   = 1'b0;
    w_rd_data  = r_rd_data;
    w_latch    = 1'b0;
    w_err_inc  = 1'b0;
    w_drop_inc = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (up_req) begin
          if (w_mapped) begin
            w_latch  = 1'b1;
            w_dn_req = NUM_SLAVES'(1) << w_sel;
            w_cnt    = '0;
            w_state  = WAIT_ACK;
          end else begin
            w_state   = RESP;
            w_err_inc = 1'b1;
            w_rd_ack  = !up_req_is_wr;
            w_wr_ack  = up_req_is_wr;
            if (!up_req_is_wr) w_rd_data = TO_DATA;
          end
        end
      end
      WAIT_ACK: begin
        w_drop_inc = up_req;
        if (r_is_wr ? w_hit_wr : w_hit_rd) begin
          w_rd_ack = !r_is_wr;
          w_wr_ack = r_is_wr;
          if (!r_is_wr) w_rd_data = w_slv_data;
          w_state = IDLE;
        end else if (r_cnt == CW'(TIMEOUT_CYCLES)) begin
          w_err_inc = 1'b1;
          w_rd_ack  = !r_is_wr;
          w_wr_ack  = r_is_wr;
          if (!r_is_wr) w_rd_data = TO_DATA;
          w_state = IDLE;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      RESP: begin
        w_drop_inc = up_req;
        w_state    = IDLE;
      end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_dn_req   <= '0;
      r_rd_ack   <= 1'b0;
      r_wr_ack   <= 1'b0;
      r_rd_data  <= '0;
      r_sel      <= '0;
      r_is_wr    <= 1'b0;
      r_addr     <= '0;
      r_wr_data  <= '0;
      r_wr_biten <= '0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_dn_req  <= w_dn_req;
      r_rd_ack  <= w_rd_ack;
      r_wr_ack  <= w_wr_ack;
      r_rd_data <= w_rd_data;
      if (w_latch) begin
        r_sel      <= w_sel;
        r_is_wr    <= up_req_is_wr;
        r_addr     <= up_addr;
        r_wr_data  <= up_wr_data;
        r_wr_biten <= up_wr_biten;
      end
    end
  end

  assign up_rd_ack    = r_rd_ack;
  assign up_wr_ack    = r_wr_ack;
  assign up_rd_data   = r_rd_data;
  assign dn_req       = r_dn_req;
  assign dn_req_is_wr = r_is_wr;
  assign dn_addr      = r_addr;
  assign dn_wr_data   = r_wr_data;
  assign dn_wr_biten  = r_wr_biten;

  sat_counter #(.WIDTH(8)) u_err_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (clear_counts),
    .i_inc   (w_err_inc),
    .o_count (err_count)
  );

  sat_counter #(.WIDTH(8)) u_drop_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (clear_counts),
    .i_inc   (w_drop_inc),
    .o_count (drop_count)
  );

endmodule

// File: tb/tb_cpu_bus_router.sv
// Self-checking bench for cpu_bus_router: vector table, hand sequences
// and randomized transactions against a transaction-level model.
module tb_cpu_bus_router;

  localparam int TO   = 64;
  localparam int TO_V = 8;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        up_req = 1'b0;
  logic        up_req_is_wr = 1'b0;
  logic [16:0] up_addr = '0;
  logic [15:0] up_wr_data = '0;
  logic [15:0] up_wr_biten = '0;
  logic        up_rd_ack, up_wr_ack;
  logic [15:0] up_rd_data;
  logic [3:0]  dn_req;
  logic        dn_req_is_wr;
  logic [16:0] dn_addr;
  logic [15:0] dn_wr_data, dn_wr_biten;
  logic [3:0]  dn_rd_ack = '0;
  logic [3:0]  dn_wr_ack = '0;
  logic [63:0] dn_rd_data = '0;
  logic        clear_counts = 1'b0;
  logic [7:0]  err_count, drop_count;

  logic        v_req = 1'b0;
  logic        v_is_wr = 1'b0;
  logic [16:0] v_addr = '0;
  logic [15:0] v_wd = '0;
  logic [15:0] v_be = '0;
  logic        v_rd_ack, v_wr_ack;
  logic [15:0] v_rd_data;
  logic [2:0]  v_dn_req;
  logic        v_dn_is_wr;
  logic [16:0] v_dn_addr;
  logic [15:0] v_dn_wd, v_dn_be;
  logic [2:0]  v_rack = '0;
  logic [2:0]  v_wack = '0;
  logic [47:0] v_rdata = '0;
  logic [7:0]  v_err, v_drop;

  cpu_bus_router #(
    .NUM_SLAVES(4), .ADDR_WIDTH(17), .DATA_WIDTH(16), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .up_req(up_req), .up_req_is_wr(up_req_is_wr), .up_addr(up_addr),
    .up_wr_data(up_wr_data), .up_wr_biten(up_wr_biten),
    .up_rd_ack(up_rd_ack), .up_wr_ack(up_wr_ack), .up_rd_data(up_rd_data),
    .dn_req(dn_req), .dn_req_is_wr(dn_req_is_wr), .dn_addr(dn_addr),
    .dn_wr_data(dn_wr_data), .dn_wr_biten(dn_wr_biten),
    .dn_rd_ack(dn_rd_ack), .dn_wr_ack(dn_wr_ack), .dn_rd_data(dn_rd_data),
    .clear_counts(clear_counts), .err_count(err_count), .drop_count(drop_count)
  );

  cpu_bus_router #(
    .NUM_SLAVES(3), .ADDR_WIDTH(17), .DATA_WIDTH(16), .TIMEOUT_CYCLES(TO_V)
  ) dut_v (
    .clk(clk), .reset_n(reset_n),
    .up_req(v_req), .up_req_is_wr(v_is_wr), .up_addr(v_addr),
    .up_wr_data(v_wd), .up_wr_biten(v_be),
    .up_rd_ack(v_rd_ack), .up_wr_ack(v_wr_ack), .up_rd_data(v_rd_data),
    .dn_req(v_dn_req), .dn_req_is_wr(v_dn_is_wr), .dn_addr(v_dn_addr),
    .dn_wr_data(v_dn_wd), .dn_wr_biten(v_dn_be),
    .dn_rd_ack(v_rack), .dn_wr_ack(v_wack), .dn_rd_data(v_rdata),
    .clear_counts(clear_counts), .err_count(v_err), .drop_count(v_drop)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int m_err = 0;
  int m_drop = 0;

  typedef struct {
    bit          wr;
    logic [16:0] addr;
    logic [15:0] wd;
    logic [15:0] be;
    int          dly;
    logic [15:0] rd;
    int          ncyc;
    int          nslv;
    bit          nwr;
    int          xcyc;
    int          resp;
    logic [15:0] data;
    bit          err;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Transaction-level expectation: ack accepted up to TO cycles after
  // the dn_req cycle (cycle 1), response one cycle after the ack.
  function automatic void model(input int dly, output int resp,
                                output bit err);
    if (dly >= 0 && dly <= TO) begin
      resp = dly + 2;
      err  = 1'b0;
    end else begin
      resp = TO + 2;
      err  = 1'b1;
    end
  endfunction

  task automatic run_txn(
    input bit wr, input logic [16:0] addr, input logic [15:0] wd,
    input logic [15:0] be, input int dly, input logic [15:0] rd,
    input int ncyc, input int nslv, input bit nwr, input int xcyc,
    input int clrc, input int resp, input logic [15:0] xdata,
    input bit xerr, input string tag);
    int sel, bad_dn, bad_ack, bad_dat, n;
    logic [3:0] x_dn;
    sel = int'(addr[16:15]);
    x_dn = 4'b0001 << sel;
    bad_dn = 0;
    bad_ack = 0;
    bad_dat = 0;
    for (int c = 0; c <= resp; c++) begin
      up_req       = (c == 0) || (c == xcyc);
      up_req_is_wr = (c == 0) ? wr : !wr;
      up_addr      = (c == 0) ? addr : 17'($urandom);
      up_wr_data   = (c == 0) ? wd : 16'($urandom);
      up_wr_biten  = (c == 0) ? be : 16'($urandom);
      dn_rd_ack    = '0;
      dn_wr_ack    = '0;
      dn_rd_data   = {$urandom, $urandom};
      if (dly >= 0 && c == dly + 1) begin
        if (wr) dn_wr_ack[sel] = 1'b1;
        else begin
          dn_rd_ack[sel] = 1'b1;
          dn_rd_data[sel*16 +: 16] = rd;
        end
      end
      if (c == ncyc) begin
        if (nwr) dn_wr_ack[nslv] = 1'b1;
        else dn_rd_ack[nslv] = 1'b1;
      end
      clear_counts = (c == clrc);
      step();
      n = c + 1;
      if (up_rd_ack !== (n == resp && !wr) ||
          up_wr_ack !== (n == resp && wr)) bad_ack++;
      if (n == resp && !wr && up_rd_data !== xdata) bad_dat++;
      if (dn_req !== ((n == 1) ? x_dn : 4'b0000)) bad_dn++;
      if (n == 1) begin
        chk({tag, " dn_addr"}, dn_addr, addr);
        chk({tag, " dn_is_wr"}, dn_req_is_wr, wr);
        if (wr) chk({tag, " dn_wdata"}, {dn_wr_data, dn_wr_biten}, {wd, be});
      end
    end
    up_req = 1'b0;
    dn_rd_ack = '0;
    dn_wr_ack = '0;
    clear_counts = 1'b0;
    if (clrc >= 0) begin
      m_err = 0;
      m_drop = 0;
    end else begin
      if (xerr && m_err < 255) m_err++;
      if (xcyc >= 0 && m_drop < 255) m_drop++;
    end
    chk({tag, " ack_timing"}, bad_ack, 0);
    if (!wr) chk({tag, " rd_data"}, bad_dat, 0);
    chk({tag, " dn_req_pulse"}, bad_dn, 0);
    chk({tag, " counts"}, {err_count, drop_count}, {8'(m_err), 8'(m_drop)});
  endtask

  initial begin : main
    int got, seen;
    logic [15:0] gdata;

    tbl[0] = '{1'b0, 17'h08004, 16'h0, 16'h0, 3, 16'h1234,
               -1, 0, 1'b0, -1, 5, 16'h1234, 1'b0};
    tbl[1] = '{1'b1, 17'h10000, 16'hA5A5, 16'h00FF, -1, 16'h0,
               -1, 0, 1'b0, -1, 66, 16'h0, 1'b1};
    tbl[2] = '{1'b0, 17'h18010, 16'h0, 16'h0, 5, 16'hBEEF,
               -1, 0, 1'b0, 2, 7, 16'hBEEF, 1'b0};
    tbl[3] = '{1'b0, 17'h08000, 16'h0, 16'h0, 64, 16'hC0DE,
               -1, 0, 1'b0, -1, 66, 16'hC0DE, 1'b0};
    tbl[4] = '{1'b0, 17'h0A000, 16'h0, 16'h0, 4, 16'h5555,
               2, 0, 1'b0, -1, 6, 16'h5555, 1'b0};
    tbl[5] = '{1'b0, 17'h00040, 16'h0, 16'h0, -1, 16'h0,
               -1, 0, 1'b0, -1, 66, 16'hDEAD, 1'b1};
    tbl[6] = '{1'b1, 17'h1FFFE, 16'h1357, 16'hF0F0, 0, 16'h0,
               -1, 0, 1'b0, -1, 2, 16'h0, 1'b0};
    tbl[7] = '{1'b0, 17'h10002, 16'h0, 16'h0, 65, 16'h7777,
               -1, 0, 1'b0, -1, 66, 16'hDEAD, 1'b1};
    tbl[8] = '{1'b1, 17'h08888, 16'h2468, 16'hFFFF, 2, 16'h0,
               1, 1, 1'b0, -1, 4, 16'h0, 1'b0};
    tbl[9] = '{1'b0, 17'h18000, 16'h0, 16'h0, 2, 16'h4321,
               0, 3, 1'b0, -1, 4, 16'h4321, 1'b0};

    repeat (3) step();
    chk("reset acks", {up_rd_ack, up_wr_ack, up_rd_data}, 0);
    chk("reset dn", {dn_req, dn_req_is_wr, dn_addr}, 0);
    chk("reset payload", {dn_wr_data, dn_wr_biten}, 0);
    chk("reset counts", {err_count, drop_count}, 0);
    reset_n = 1'b1;

    // unmapped slave on the 3-slave instance, with a drop during RESP
    v_req = 1'b1; v_is_wr = 1'b0; v_addr = 17'h18000;
    step();
    chk("v unmapped rd_ack", {v_rd_ack, v_wr_ack}, 2'b10);
    chk("v unmapped data", v_rd_data, 16'hDEAD);
    chk("v unmapped dn_req", v_dn_req, 3'b000);
    step();
    v_req = 1'b0;
    chk("v resp one cycle", {v_rd_ack, v_wr_ack, v_dn_req}, 0);
    step();
    chk("v counts", {v_err, v_drop}, {8'd1, 8'd1});
    v_req = 1'b1; v_is_wr = 1'b1; v_addr = 17'h1C000;
    step();
    v_req = 1'b0;
    chk("v unmapped wr_ack", {v_rd_ack, v_wr_ack, v_dn_req}, 5'b01000);
    step();
    chk("v wr_ack drop", {v_rd_ack, v_wr_ack}, 0);
    v_req = 1'b1; v_is_wr = 1'b0; v_addr = 17'h10000;
    step();
    v_req = 1'b0;
    chk("v mapped dn_req", v_dn_req, 3'b100);
    got = -1;
    gdata = '0;
    for (int k = 2; k <= 30 && got < 0; k++) begin
      step();
      if (v_rd_ack) begin
        got = k;
        gdata = v_rd_data;
      end
    end
    chk("v timeout latency", got, TO_V + 2);
    chk("v timeout data", gdata, 16'hDEAD);
    chk("v err total", v_err, 8'd3);

    for (int i = 0; i < 10; i++)
      run_txn(tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].be, tbl[i].dly,
              tbl[i].rd, tbl[i].ncyc, tbl[i].nslv, tbl[i].nwr,
              tbl[i].xcyc, -1, tbl[i].resp, tbl[i].data, tbl[i].err,
              $sformatf("vec%0d", i));

    for (int t = 0; t < 40; t++) begin
      bit wr, e, nwr;
      logic [16:0] a;
      logic [15:0] rd;
      int dly, resp, ncyc, nslv, xcyc, s, r;
      wr = 1'($urandom_range(0, 1));
      a = 17'($urandom);
      s = int'(a[16:15]);
      rd = 16'($urandom);
      r = $urandom_range(0, 9);
      if (r < 5) dly = $urandom_range(0, 8);
      else if (r < 8) dly = $urandom_range(TO - 2, TO + 2);
      else dly = -1;
      model(dly, resp, e);
      ncyc = -1; nslv = 0; nwr = 1'b0; xcyc = -1;
      if ($urandom_range(0, 1) == 1) begin
        ncyc = $urandom_range(0, resp - 2);
        if ($urandom_range(0, 1) == 1) begin
          nslv = (s + 1) % 4;
          nwr = 1'($urandom_range(0, 1));
        end else begin
          nslv = s;
          nwr = !wr;
        end
      end
      if ($urandom_range(0, 2) == 0) xcyc = $urandom_range(1, resp - 1);
      run_txn(wr, a, 16'($urandom), 16'($urandom), dly, rd, ncyc, nslv,
              nwr, xcyc, -1, resp, e ? 16'hDEAD : rd, e,
              $sformatf("rnd%0d", t));
    end

    for (int t = 0; t < 300; t++)
      run_txn(1'($urandom_range(0, 1)), 17'($urandom), 16'h0, 16'h0, -1,
              16'h0, -1, 0, 1'b0, -1, -1, TO + 2, 16'hDEAD, 1'b1, "sat");
    chk("err saturated", err_count, 8'd255);

    clear_counts = 1'b1;
    step();
    clear_counts = 1'b0;
    m_err = 0;
    m_drop = 0;
    chk("clear counts", {err_count, drop_count}, 0);

    // clear on the very cycle the timeout increment happens
    run_txn(1'b0, 17'h08010, 16'h0, 16'h0, -1, 16'h0, -1, 0, 1'b0, 3,
            TO + 1, TO + 2, 16'hDEAD, 1'b1, "clr_coinc");
    run_txn(1'b1, 17'h00020, 16'h1111, 16'h000F, 1, 16'h0, -1, 0, 1'b0, 1,
            -1, 3, 16'h0, 1'b0, "pre_rst");

    up_req = 1'b1; up_req_is_wr = 1'b0; up_addr = 17'h08000;
    step();
    up_req = 1'b0;
    chk("rst dn_req", dn_req, 4'b0010);
    step();
    step();
    reset_n = 1'b0;
    #1;
    chk("rst async outs", {up_rd_ack, up_wr_ack, dn_req, dn_addr}, 0);
    step();
    chk("rst counts", {err_count, drop_count}, 0);
    reset_n = 1'b1;
    m_err = 0;
    m_drop = 0;
    seen = 0;
    for (int k = 0; k < 80; k++) begin
      dn_rd_ack = (k == 1 || k == 3 || k == 70) ? 4'b0010 : 4'b0000;
      dn_wr_ack = (k == 2) ? 4'b0010 : 4'b0000;
      step();
      if (up_rd_ack || up_wr_ack || dn_req != 4'b0000) seen++;
    end
    dn_rd_ack = '0;
    dn_wr_ack = '0;
    chk("rst abandoned", seen, 0);
    chk("rst counts after", {err_count, drop_count}, 0);

    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    run_txn(1'b1, 17'h10004, 16'hCAFE, 16'h0F0F, 1, 16'h0, -1, 0, 1'b0, -1,
            -1, 3, 16'h0, 1'b0, "first_after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
